uart_tx_frame_sequencer: RTL and testbench

Complete 8N1/8N2 UART transmit framer. It accepts a byte over a valid/ready handshake and serialises it onto `tx` as a start bit, data bits LSB first, and one or two stop bits. It owns its own baud-period counter and is the stage that drives the stop-bit stage of the transmit path. Its `tx` output connects directly to the board pin.

---
 rtl/uart_tx_frame_sequencer.sv | 124 ++++++++++++
 tb/tb_uart_tx_frame_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_sequencer.sv
// UART transmit framer: accepts one word over valid/ready and serialises it as
// start bit, DataBits data bits LSB first, then StopBits stop bits on tx.
module uart_tx_frame_sequencer #(
    parameter int ClockFrequency = 1000000,
    parameter int BaudRate       = 9600,
    parameter int DataBits       = 8,
    parameter int StopBits       = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DataBits-1:0] data,
    input  logic                dataValid,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic                tx
);

    localparam int BitCycles  = ClockFrequency / BaudRate;
    localparam int StopCycles = StopBits * BitCycles;
    localparam int CountWidth = (StopCycles > 1) ? $clog2(StopCycles) : 1;
    localparam int IndexWidth = $clog2(DataBits);

    localparam logic [CountWidth-1:0] BIT_LAST   = CountWidth'(BitCycles - 1);
    localparam logic [CountWidth-1:0] STOP_LAST  = CountWidth'(StopCycles - 1);
    localparam logic [IndexWidth-1:0] INDEX_LAST = IndexWidth'(DataBits - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    generate
        if (BitCycles < 2) begin : g_bad_bit_cycles
            $error("ClockFrequency / BaudRate must be at least 2");
        end
        if (DataBits < 5 || DataBits > 8) begin : g_bad_data_bits
            $error("DataBits must be in the range 5..8");
        end
        if (StopBits < 1 || StopBits > 2) begin : g_bad_stop_bits
            $error("StopBits must be 1 or 2");
        end
    endgenerate

    logic [1:0]            state;
    logic [CountWidth-1:0] bit_count;
    logic [IndexWidth-1:0] bit_index;
    logic [DataBits-1:0]   shift_reg;

    // NOTE: every register, including the datapath, is given a reset value so a
    // mid-frame reset leaves no stale bits behind for the next frame.
    // NOTE: sequential state uses non-blocking assignments only, so every branch
    // below reads the values from before the clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_count <= '0;
            bit_index <= '0;
            shift_reg <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dataValid) begin
                        shift_reg <= data;
                        tx        <= 1'b0;
                        bit_count <= '0;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_count == BIT_LAST) begin
                        bit_count <= '0;
                        bit_index <= '0;
                        tx        <= shift_reg[0];
                        state     <= DATA;
                    end else begin
                        bit_count <= bit_count + CountWidth'(1);
                    end
                end
                DATA: begin
                    if (bit_count == BIT_LAST) begin
                        bit_count <= '0;
                        if (bit_index == INDEX_LAST) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // Present the next bit while shifting it down to bit 0.
                            bit_index <= bit_index + IndexWidth'(1);
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        bit_count <= bit_count + CountWidth'(1);
                    end
                end
                STOP: begin
                    if (bit_count == STOP_LAST) begin
                        bit_count <= '0;
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        bit_count <= bit_count + CountWidth'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_sequencer.sv
// Directed bench for uart_tx_frame_sequencer: a BitCycles=4 8N1 instance and a
// 1 MHz / 9600 7N2 instance, checked at fixed cycle offsets from acceptance.
module tb_uart_tx_frame_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       data_valid;
    logic       ready, busy, done, tx;

    logic [6:0] data2;
    logic       data_valid2;
    logic       ready2, busy2, done2, tx2;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    uart_tx_frame_sequencer #(
        .ClockFrequency(16),
        .BaudRate      (4),
        .DataBits      (8),
        .StopBits      (1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .data     (data),
        .dataValid(data_valid),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .tx       (tx)
    );

    uart_tx_frame_sequencer #(
        .ClockFrequency(1000000),
        .BaudRate      (9600),
        .DataBits      (7),
        .StopBits      (2)
    ) dut2 (
        .clock    (clock),
        .reset    (reset),
        .data     (data2),
        .dataValid(data_valid2),
        .ready    (ready2),
        .busy     (busy2),
        .done     (done2),
        .tx       (tx2)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One 8N1 frame on the BitCycles=4 instance; optionally scramble inputs while busy.
    task automatic send_frame(input logic [7:0] value, input bit scramble);
        logic [7:0] word;
        logic       expected_tx;
        word = value;
        check("pre_ready", ready, 1'b1);
        data       = word;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (j < 4)       expected_tx = 1'b0;
            else if (j < 36) expected_tx = word[(j - 4) / 4];
            else             expected_tx = 1'b1;
            check("frame_tx", tx, expected_tx);
            check("frame_busy", busy, 1'b1);
            check("frame_ready", ready, 1'b0);
            check("frame_done", done, 1'b0);
            if (scramble) begin
                data       = 8'($urandom);
                data_valid = ~data_valid;
            end
            tick();
        end
        data_valid = 1'b0;
        check("end_done", done, 1'b1);
        check("end_busy", busy, 1'b0);
        check("end_ready", ready, 1'b1);
        check("end_tx", tx, 1'b1);
        tick();
        check("done_drop", done, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        data        = 8'h00;
        data_valid  = 1'b0;
        data2       = 7'h00;
        data_valid2 = 1'b0;
        #2 reset = 1'b0;

        // Reset values held for three cycles, then idle after release.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_tx", tx, 1'b1);
            check("rst_ready", ready, 1'b1);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
        end
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_tx", tx, 1'b1);
            check("idle_busy", busy, 1'b0);
        end
        check("idle_ready2", ready2, 1'b1);

        // Single byte: 0,1,0,1,0,0,1,0,1 then stop.
        send_frame(8'hA5, 1'b0);

        // Back-to-back with dataValid held high.
        tick();
        data       = 8'h00;
        data_valid = 1'b1;
        tick();
        data = 8'hFF;
        check("b2b_start1", tx, 1'b0);
        tick_n(20);
        check("b2b_bit4_zero", tx, 1'b0);
        tick_n(19);
        check("b2b_stop1_tx", tx, 1'b1);
        check("b2b_stop1_busy", busy, 1'b1);
        tick();
        check("b2b_done1", done, 1'b1);
        check("b2b_gap_ready", ready, 1'b1);
        check("b2b_gap_tx", tx, 1'b1);
        tick();
        check("b2b_start2_tx", tx, 1'b0);
        check("b2b_start2_busy", busy, 1'b1);
        check("b2b_start2_done", done, 1'b0);
        tick_n(4);
        check("b2b_ff_bit0", tx, 1'b1);
        data_valid = 1'b0;
        tick_n(35);
        check("b2b_stop2_busy", busy, 1'b1);
        tick();
        check("b2b_done2", done, 1'b1);
        tick();
        check("b2b_done2_drop", done, 1'b0);
        check("b2b_no_third", busy, 1'b0);
        tick_n(3);
        check("b2b_still_idle", tx, 1'b1);

        // Inputs scrambled every cycle while busy.
        send_frame(8'h3C, 1'b1);

        // Reset during data bit 3 of 8'h00.
        tick();
        data       = 8'h00;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        tick_n(17);
        check("mid_bit3_tx", tx, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("mid_async_tx", tx, 1'b1);
        check("mid_async_busy", busy, 1'b0);
        check("mid_async_ready", ready, 1'b1);
        check("mid_async_done", done, 1'b0);
        tick_n(2);
        #2 reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("mid_no_done", done, 1'b0);
            check("mid_idle_tx", tx, 1'b1);
        end
        send_frame(8'h5A, 1'b0);

        // 7N2 at 104 cycles per bit, data 7'h15 (bits 1,0,1,0,1,0,0).
        data2       = 7'h15;
        data_valid2 = 1'b1;
        tick();
        data_valid2 = 1'b0;
        check("v_start_tx", tx2, 1'b0);
        check("v_start_busy", busy2, 1'b1);
        tick_n(103);
        check("v_start_end", tx2, 1'b0);
        tick();
        check("v_bit0", tx2, 1'b1);
        tick_n(104);
        check("v_bit1", tx2, 1'b0);
        tick_n(623);
        check("v_bit6_end", tx2, 1'b0);
        tick();
        check("v_stop_start", tx2, 1'b1);
        tick_n(207);
        check("v_stop_end_busy", busy2, 1'b1);
        check("v_stop_end_done", done2, 1'b0);
        tick();
        check("v_done", done2, 1'b1);
        check("v_ready", ready2, 1'b1);
        check("v_busy", busy2, 1'b0);
        tick();
        check("v_done_drop", done2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
